ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Single-clock front end for the `ram` block (D_WIDTH/A_WIDTH/A_MAX parameterised), with the RAM's clk_write and clk_read both tied to this block's clk.
- After reset, zero-fills every RAM location.
- Then shares the RAM's write and read ports between two requesters using round-robin arbitration, one transaction per cycle.
- Returns read data to the requester that issued the read, with a valid strobe.

Parameters:
D_WIDTH, 8, data word width
A_WIDTH, 5, address width
A_MAX, 32, number of implemented RAM locations (A_MAX <= 2**A_WIDTH)

Ports:
clk  input  1  single clock for arbiter and RAM (drives RAM clk_write and clk_read)
reset  input  1  synchronous, active-high reset
req0  input  1  requester 0 transaction request
we0  input  1  requester 0: 1=write, 0=read
addr0  input  A_WIDTH  requester 0 address
wdata0  input  D_WIDTH  requester 0 write data
gnt0  output  1  requester 0 grant (combinational, same cycle as accepted req0)
rvalid0  output  1  requester 0 read data valid
rdata0  output  D_WIDTH  requester 0 read data
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  same as above for requester 1
init_done  output  1  high once zero-fill is complete
ram_address_write  output  A_WIDTH  to RAM address_write
ram_data_write  output  D_WIDTH  to RAM data_write
ram_write_enable  output  1  to RAM write_enable
ram_address_read  output  A_WIDTH  to RAM address_read
ram_data_read  input  D_WIDTH  from RAM data_read (registered in RAM; valid 1 cycle after address)

Behaviour:
- Reset (sync, any cycle):
  - State goes to CLEAR; clear_ptr=0; last_gnt=1, so requester 0 wins the first tie.
  - init_done=0, gnt0/1=0, rvalid0/1=0, rdata0/1=0.
  - In-flight reads are discarded; no rvalid follows a reset.
- FSM states: CLEAR, SERVE.
- CLEAR:
  - Each cycle drives ram_write_enable=1, ram_address_write=clear_ptr, ram_data_write=0; clear_ptr increments.
  - When clear_ptr==A_MAX-1, that location is written and the next state is SERVE.
  - CLEAR lasts exactly A_MAX cycles. Requests are ignored (gnt=0) and may be held.
  - init_done is registered: 1 from the first SERVE cycle until reset.
- SERVE arbitration (combinational):
  - Exactly one request: grant it.
  - Both requesting: grant the requester != last_gnt.
  - last_gnt updates on the clock edge ending any granted cycle.
  - At most one gnt per cycle. gnt never asserts without the matching req.
- Request protocol:
  - Requester holds req/we/addr/wdata stable until gnt; the transaction completes in the gnt cycle.
  - Keeping req high after gnt issues a new transaction.
  - Both held high continuously gives strict alternation 0,1,0,1...
- Write:
  - Granted write drives ram_address_write=addr, ram_data_write=wdata, ram_write_enable=1 in the gnt cycle.
  - The RAM commits at the end of that cycle.
- Read:
  - Granted read drives ram_address_read=addr in the gnt cycle.
  - Next cycle: rvalidN=1 for exactly one cycle, rdataN=ram_data_read. Latency = 1 cycle after gnt.
  - rdataN holds its last value when rvalidN=0.
  - Owner and out-of-range flag are registered with the read.
- Idle / default outputs:
  - ram_write_enable=0 when no write is granted and not in CLEAR.
  - ram_address_read holds its last value (no spurious reads matter; data is ignored without rvalid).
- Out of range (addr >= A_MAX, only possible when A_MAX < 2**A_WIDTH):
  - The request is still granted, so the requester never hangs.
  - Write: ram_write_enable is suppressed.
  - Read: rvalid still pulses, with rdata forced to 0.
- Read-after-write: a read granted the cycle after a write to the same address returns the new data. The arbiter never issues a read and a write in the same cycle.
- Back-to-back reads from alternating requesters: rvalid0 and rvalid1 are never both high; each follows its own gnt by 1 cycle.

Test Plan:
- Reset, hold req0=1 read addr 5'h1B through init -> gnt0=0 for 32 cycles; init_done rises at cycle 32; gnt0 at cycle 32; rvalid0 at cycle 33 with rdata0=8'h00.
- Post-init: req0 write addr 5'h1B data 8'hC5, then req0 read 5'h1B -> ram_write_enable=1 for one cycle; rvalid0 one cycle after read gnt, rdata0=8'hC5.
- Both req held, req0 write 5'h03 data 8'hAA and req1 read 5'h03 on the same cycle -> gnt0 first, gnt1 next cycle; rvalid1 with rdata1=8'hAA.
- Both req held continuously for 6 cycles (reads of 5'h01/5'h02) -> grants alternate 0,1,0,1,0,1; rvalid0 and rvalid1 never coincide.
- Instance with A_MAX=20: write to 5'h18 then read it -> no RAM write; rvalid pulses with rdata=8'h00; CLEAR lasts 20 cycles.
- Assert reset for one cycle during SERVE while a read is in flight -> no rvalid next cycle; init_done=0; new 32-cycle CLEAR; prior data reads back 8'h00.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Single-clock front end for a dual-port RAM. After reset it zero-fills
// every implemented location. It then shares the RAM write and read ports
// between two requesters with round-robin arbitration, one transaction per
// cycle. Read data goes back to the requester that issued the read.
//
// Ports:
//   clk, reset            clock for arbiter and RAM; synchronous active-high reset
//   reqN/weN/addrN/wdataN requester N transaction (we=1 write, 0 read)
//   gntN                  combinational grant, same cycle as the accepted request
//   rvalidN/rdataN        read return, one cycle after the read grant
//   init_done             high once the zero-fill has finished
//   ram_*                 connections to the RAM write and read ports;
//                         ram_data_read is registered inside the RAM
module ram_port_arbiter #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 5,
  parameter int A_MAX   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic               we0,
  input  logic [A_WIDTH-1:0] addr0,
  input  logic [D_WIDTH-1:0] wdata0,
  output logic               gnt0,
  output logic               rvalid0,
  output logic [D_WIDTH-1:0] rdata0,
  input  logic               req1,
  input  logic               we1,
  input  logic [A_WIDTH-1:0] addr1,
  input  logic [D_WIDTH-1:0] wdata1,
  output logic               gnt1,
  output logic               rvalid1,
  output logic [D_WIDTH-1:0] rdata1,
  output logic               init_done,
  output logic [A_WIDTH-1:0] ram_address_write,
  output logic [D_WIDTH-1:0] ram_data_write,
  output logic               ram_write_enable,
  output logic [A_WIDTH-1:0] ram_address_read,
  input  logic [D_WIDTH-1:0] ram_data_read
);

  typedef enum logic {CLEAR, SERVE} state_t;

  localparam logic [A_WIDTH-1:0] LAST_PTR   = A_WIDTH'(A_MAX - 1);
  localparam logic [A_WIDTH:0]   ADDR_LIMIT = (A_WIDTH + 1)'(A_MAX);

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] clear_ptr_q;
  logic               last_gnt_q;
  logic               init_done_q;
  logic               pend0_q, pend1_q, pend_oor_q;
  logic [D_WIDTH-1:0] rhold0_q, rhold1_q;
  logic [A_WIDTH-1:0] addr_read_q;

  logic               grant_any;
  logic               sel;
  logic               g_we;
  logic [A_WIDTH-1:0] g_addr;
  logic [D_WIDTH-1:0] g_wdata;
  logic               in_range;
  logic [D_WIDTH-1:0] read_value;

  // Next-state, arbitration and RAM port drive. Everything is quiet while
  // reset is high so no grant or write escapes during a reset cycle.
  // When both requesters ask, the one that did not win last time is picked.
  always_comb begin
    state_d           = state_q;
    grant_any         = 1'b0;
    sel               = 1'b0;
    g_we              = 1'b0;
    g_addr            = '0;
    g_wdata           = '0;
    in_range          = 1'b1;
    gnt0              = 1'b0;
    gnt1              = 1'b0;
    ram_write_enable  = 1'b0;
    ram_address_write = clear_ptr_q;
    ram_data_write    = '0;
    ram_address_read  = addr_read_q;
    if (!reset) begin
      case (state_q)
        CLEAR: begin
          ram_write_enable = 1'b1;
          if (clear_ptr_q == LAST_PTR) state_d = SERVE;
        end
        SERVE: begin
          grant_any = req0 | req1;
          if (req0 && req1) sel = ~last_gnt_q;
          else              sel = req1;
          g_we     = sel ? we1    : we0;
          g_addr   = sel ? addr1  : addr0;
          g_wdata  = sel ? wdata1 : wdata0;
          in_range = ({1'b0, g_addr} < ADDR_LIMIT);
          gnt0     = grant_any & ~sel;
          gnt1     = grant_any & sel;
          if (grant_any) begin
            if (g_we) begin
              ram_address_write = g_addr;
              ram_data_write    = g_wdata;
              ram_write_enable  = in_range;
            end else begin
              ram_address_read = g_addr;
            end
          end
        end
        default: state_d = CLEAR;
      endcase
    end
  end

  // Read return path. The RAM output is only meaningful in the cycle after a
  // read grant; otherwise each requester sees the last value it was given.
  always_comb begin
    read_value = pend_oor_q ? '0 : ram_data_read;
    rvalid0    = pend0_q & ~reset;
    rvalid1    = pend1_q & ~reset;
    rdata0     = reset ? '0 : (pend0_q ? read_value : rhold0_q);
    rdata1     = reset ? '0 : (pend1_q ? read_value : rhold1_q);
    init_done  = init_done_q;
  end

  // State register plus the per-read owner and out-of-range tags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CLEAR;
      clear_ptr_q <= '0;
      last_gnt_q  <= 1'b1;
      init_done_q <= 1'b0;
      pend0_q     <= 1'b0;
      pend1_q     <= 1'b0;
      pend_oor_q  <= 1'b0;
      rhold0_q    <= '0;
      rhold1_q    <= '0;
      addr_read_q <= '0;
    end else begin
      state_q     <= state_d;
      init_done_q <= (state_d == SERVE);
      if (state_q == CLEAR) clear_ptr_q <= clear_ptr_q + 1'b1;
      if (grant_any) last_gnt_q <= sel;
      pend0_q     <= grant_any & ~g_we & ~sel;
      pend1_q     <= grant_any & ~g_we & sel;
      pend_oor_q  <= ~in_range;
      rhold0_q    <= rdata0;
      rhold1_q    <= rdata1;
      addr_read_q <= ram_address_read;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
// Bench for ram_port_arbiter. Instance "a" uses the default 32-location
// geometry and is checked every cycle against a behavioural model (memory
// array, zero-fill countdown, round-robin winner, pending read). Instance
// "b" has A_MAX=20 and gets directed out-of-range checks.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  // ---------------- instance a (A_MAX = 32) ----------------
  logic       reset = 1'b1;
  logic       req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [4:0] addr0 = 0, addr1 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0;
  logic       gnt0, gnt1, rvalid0, rvalid1, init_done;
  logic [7:0] rdata0, rdata1;
  logic [4:0] ram_address_write, ram_address_read;
  logic [7:0] ram_data_write, ram_data_read;
  logic       ram_write_enable;

  ram_port_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .init_done(init_done),
    .ram_address_write(ram_address_write), .ram_data_write(ram_data_write),
    .ram_write_enable(ram_write_enable), .ram_address_read(ram_address_read),
    .ram_data_read(ram_data_read)
  );

  // ---------------- instance b (A_MAX = 20) ----------------
  logic       reset_b = 1'b1;
  logic       req0_b = 0, we0_b = 0, req1_b = 0, we1_b = 0;
  logic [4:0] addr0_b = 0, addr1_b = 0;
  logic [7:0] wdata0_b = 0, wdata1_b = 0;
  logic       gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, init_done_b;
  logic [7:0] rdata0_b, rdata1_b;
  logic [4:0] ram_address_write_b, ram_address_read_b;
  logic [7:0] ram_data_write_b, ram_data_read_b;
  logic       ram_write_enable_b;

  ram_port_arbiter #(.D_WIDTH(8), .A_WIDTH(5), .A_MAX(20)) dut_b (
    .clk(clk), .reset(reset_b),
    .req0(req0_b), .we0(we0_b), .addr0(addr0_b), .wdata0(wdata0_b),
    .gnt0(gnt0_b), .rvalid0(rvalid0_b), .rdata0(rdata0_b),
    .req1(req1_b), .we1(we1_b), .addr1(addr1_b), .wdata1(wdata1_b),
    .gnt1(gnt1_b), .rvalid1(rvalid1_b), .rdata1(rdata1_b),
    .init_done(init_done_b),
    .ram_address_write(ram_address_write_b), .ram_data_write(ram_data_write_b),
    .ram_write_enable(ram_write_enable_b), .ram_address_read(ram_address_read_b),
    .ram_data_read(ram_data_read_b)
  );

  // RAMs seen by the two instances: registered read, write at the edge.
  // Start with nonzero contents so the zero-fill is observable.
  logic [7:0] mem_a [32];
  logic [7:0] mem_b [32];
  initial begin
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = 8'(i * 7 + 1) | 8'h01;
      mem_b[i] = 8'hA5;
    end
  end
  always @(posedge clk) begin
    if (ram_write_enable)   mem_a[ram_address_write]   <= ram_data_write;
    if (ram_write_enable_b) mem_b[ram_address_write_b] <= ram_data_write_b;
    ram_data_read   <= mem_a[ram_address_read];
    ram_data_read_b <= mem_b[ram_address_read_b];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                  name, actual, expected, $time);
  endtask

  // ---------------- behavioural model of instance a ----------------
  bit         model_on = 0;
  int         clear_left = 32;
  int         last_winner = 1;
  int         pend_owner = -1;
  logic [7:0] pend_data;
  logic [7:0] held [2];
  logic [7:0] model_mem [32];
  int         winner;
  bit         cur_we;
  logic [4:0] cur_addr;
  logic [7:0] cur_wdata;

  // Inputs change just after the rising edge, so at the falling edge they
  // are the values the next rising edge will sample. Compare first, then
  // advance the model by one clock.
  always @(negedge clk) begin
    winner = -1;
    if (!reset && clear_left == 0) begin
      if (req0 && req1) winner = 1 - last_winner;
      else if (req0)    winner = 0;
      else if (req1)    winner = 1;
    end
    cur_we    = (winner == 1) ? we1    : we0;
    cur_addr  = (winner == 1) ? addr1  : addr0;
    cur_wdata = (winner == 1) ? wdata1 : wdata0;

    if (model_on) begin
      if (reset) begin
        checkOutput("m_rst_gnt0", gnt0, 0);
        checkOutput("m_rst_gnt1", gnt1, 0);
        checkOutput("m_rst_rvalid0", rvalid0, 0);
        checkOutput("m_rst_rvalid1", rvalid1, 0);
        checkOutput("m_rst_rdata0", rdata0, 0);
        checkOutput("m_rst_rdata1", rdata1, 0);
      end else begin
        checkOutput("m_init_done", init_done, (clear_left == 0) ? 1 : 0);
        checkOutput("m_gnt0", gnt0, (winner == 0) ? 1 : 0);
        checkOutput("m_gnt1", gnt1, (winner == 1) ? 1 : 0);
        if (clear_left > 0) begin
          checkOutput("m_clear_we", ram_write_enable, 1);
          checkOutput("m_clear_addr", ram_address_write, 32 - clear_left);
          checkOutput("m_clear_data", ram_data_write, 0);
        end else begin
          checkOutput("m_we", ram_write_enable, (winner >= 0 && cur_we) ? 1 : 0);
          if (winner >= 0 && cur_we) begin
            checkOutput("m_waddr", ram_address_write, cur_addr);
            checkOutput("m_wdata", ram_data_write, cur_wdata);
          end
          if (winner >= 0 && !cur_we)
            checkOutput("m_raddr", ram_address_read, cur_addr);
        end
        checkOutput("m_rvalid0", rvalid0, (pend_owner == 0) ? 1 : 0);
        checkOutput("m_rvalid1", rvalid1, (pend_owner == 1) ? 1 : 0);
        checkOutput("m_rdata0", rdata0, (pend_owner == 0) ? pend_data : held[0]);
        checkOutput("m_rdata1", rdata1, (pend_owner == 1) ? pend_data : held[1]);
      end
    end

    if (reset) begin
      model_on    = 1;
      clear_left  = 32;
      last_winner = 1;
      pend_owner  = -1;
      held[0]     = 8'h00;
      held[1]     = 8'h00;
    end else if (model_on) begin
      if (pend_owner >= 0) held[pend_owner] = pend_data;
      pend_owner = -1;
      if (clear_left > 0) begin
        model_mem[32 - clear_left] = 8'h00;
        clear_left--;
      end else if (winner >= 0) begin
        last_winner = winner;
        if (cur_we) model_mem[cur_addr] = cur_wdata;
        else begin
          pend_owner = winner;
          pend_data  = model_mem[cur_addr];
        end
      end
    end
  end

  // Random traffic on instance a: each requester keeps its transaction
  // until granted, then picks a fresh one. Rare one-cycle resets.
  task automatic applyStimulus(input int cycles);
    bit g0 = 1, g1 = 1;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 399) == 0);
      if (g0 || !req0) begin
        req0   = ($urandom_range(0, 3) != 0);
        we0    = 1'($urandom_range(0, 1));
        addr0  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        wdata0 = 8'($urandom);
      end
      if (g1 || !req1) begin
        req1   = ($urandom_range(0, 3) != 0);
        we1    = 1'($urandom_range(0, 1));
        addr1  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        wdata1 = 8'($urandom);
      end
      @(negedge clk);
      g0 = gnt0;
      g1 = gnt1;
    end
    @(posedge clk); #1;
    reset = 0; req0 = 0; req1 = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    // Zero-fill with a read of 5'h1B held throughout.
    repeat (2) @(posedge clk);
    #1;
    reset = 0; req0 = 1; we0 = 0; addr0 = 5'h1B;
    n = 0;
    @(negedge clk);
    while (!gnt0 && n < 100) begin
      if (n == 31) checkOutput("init_low_at_31", init_done, 0);
      n++;
      @(negedge clk);
    end
    checkOutput("clear_len_32", n, 32);
    checkOutput("init_done_rise", init_done, 1);
    step(); req0 = 0;
    @(negedge clk);
    checkOutput("first_rvalid0", rvalid0, 1);
    checkOutput("first_rdata0", rdata0, 8'h00);

    // Write then read back 5'h1B.
    step(); req0 = 1; we0 = 1; addr0 = 5'h1B; wdata0 = 8'hC5;
    @(negedge clk);
    checkOutput("wr_gnt0", gnt0, 1);
    checkOutput("wr_we", ram_write_enable, 1);
    step(); we0 = 0;
    @(negedge clk);
    checkOutput("rd_gnt0", gnt0, 1);
    checkOutput("rd_we_low", ram_write_enable, 0);
    step(); req0 = 0;
    @(negedge clk);
    checkOutput("rd_rvalid0", rvalid0, 1);
    checkOutput("rd_rdata0", rdata0, 8'hC5);

    // Requester 1 reads alone, then both collide on 5'h03.
    step(); req1 = 1; we1 = 0; addr1 = 5'h1B;
    @(negedge clk);
    checkOutput("solo_gnt1", gnt1, 1);
    step(); req0 = 1; we0 = 1; addr0 = 5'h03; wdata0 = 8'hAA; addr1 = 5'h03;
    @(negedge clk);
    checkOutput("solo_rdata1", rdata1, 8'hC5);
    checkOutput("tie_gnt0", gnt0, 1);
    checkOutput("tie_gnt1_low", gnt1, 0);
    step(); req0 = 0;
    @(negedge clk);
    checkOutput("tie_gnt1_next", gnt1, 1);
    step(); req1 = 0;
    @(negedge clk);
    checkOutput("raw_rvalid1", rvalid1, 1);
    checkOutput("raw_rdata1", rdata1, 8'hAA);

    // Both held for six cycles: strict alternation.
    step(); req0 = 1; we0 = 0; addr0 = 5'h01; req1 = 1; we1 = 0; addr1 = 5'h02;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("alt_gnt0", gnt0, (i % 2 == 0) ? 1 : 0);
      checkOutput("alt_gnt1", gnt1, (i % 2 == 1) ? 1 : 0);
      checkOutput("rvalid_exclusive", rvalid0 & rvalid1, 0);
      if (i < 5) step();
    end
    step(); req0 = 0; req1 = 0;

    // Reset while a read is in flight.
    step(); req0 = 1; we0 = 1; addr0 = 5'h07; wdata0 = 8'h3C;
    @(negedge clk);
    checkOutput("pre_rst_wr_gnt0", gnt0, 1);
    step(); we0 = 0;
    @(negedge clk);
    checkOutput("pre_rst_rd_gnt0", gnt0, 1);
    step(); req0 = 0; reset = 1;
    @(negedge clk);
    checkOutput("rvalid_in_reset", rvalid0, 0);
    step(); reset = 0; req0 = 1; we0 = 0; addr0 = 5'h07;
    n = 0;
    @(negedge clk);
    checkOutput("rvalid_after_reset", rvalid0, 0);
    checkOutput("init_low_after_reset", init_done, 0);
    while (!gnt0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput("reclear_len_32", n, 32);
    step(); req0 = 0;
    @(negedge clk);
    checkOutput("reclear_rvalid0", rvalid0, 1);
    checkOutput("reclear_rdata0", rdata0, 8'h00);

    applyStimulus(3000);

    // Instance b: 20-location RAM with out-of-range accesses.
    step(); reset_b = 1;
    step(); reset_b = 0; req0_b = 1; we0_b = 1; addr0_b = 5'h18; wdata0_b = 8'h5A;
    n = 0;
    @(negedge clk);
    while (!gnt0_b && n < 100) begin
      if (n == 19) begin
        checkOutput("b_last_clear_addr", ram_address_write_b, 19);
        checkOutput("b_last_clear_we", ram_write_enable_b, 1);
      end
      n++;
      @(negedge clk);
    end
    checkOutput("b_clear_len_20", n, 20);
    checkOutput("b_init_done", init_done_b, 1);
    checkOutput("b_oor_we_blocked", ram_write_enable_b, 0);
    step(); we0_b = 0;
    @(negedge clk);
    checkOutput("b_oor_rd_gnt0", gnt0_b, 1);
    step(); req0_b = 0;
    @(negedge clk);
    checkOutput("b_oor_rvalid0", rvalid0_b, 1);
    checkOutput("b_oor_rdata0", rdata0_b, 8'h00);
    step(); req1_b = 1; we1_b = 1; addr1_b = 5'h13; wdata1_b = 8'h77;
    @(negedge clk);
    checkOutput("b_top_wr_gnt1", gnt1_b, 1);
    checkOutput("b_top_wr_we", ram_write_enable_b, 1);
    step(); we1_b = 0;
    @(negedge clk);
    checkOutput("b_top_rd_gnt1", gnt1_b, 1);
    step(); req1_b = 0;
    @(negedge clk);
    checkOutput("b_top_rvalid1", rvalid1_b, 1);
    checkOutput("b_top_rdata1", rdata1_b, 8'h77);
    checkOutput("b_rvalid0_quiet", rvalid0_b, 0);
    checkOutput("b_oor_mem_untouched", mem_b[24], 8'hA5);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
